// File: rtl/crypto_block_responder.sv
// crypto_block_responder: block-interface endpoint wrapping a deterministic iterative
// known-answer round engine with start/ready/done/idle handshake.
module crypto_block_responder #(
    parameter int WIDTH  = 128,
    parameter int ROUNDS = 10
) (
    input  logic             crypto_clk,
    input  logic             crypto_rst,
    input  logic [WIDTH-1:0] crypto_keyout,
    input  logic [WIDTH-1:0] crypto_textout,
    input  logic             crypto_start,
    output logic [WIDTH-1:0] crypto_cipherin,
    output logic             crypto_ready,
    output logic             crypto_done,
    output logic             crypto_idle
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_next;
    logic [WIDTH-1:0] st, key_reg, st_round;
    logic [7:0] rnd;
    logic accept, last;

    always_comb begin
        accept     = (state == IDLE) && crypto_start;
        last       = (state == RUN) && (rnd == 8'(ROUNDS));
        st_round   = {st[WIDTH-2:0], st[WIDTH-1]} ^ key_reg ^ {{(WIDTH-8){1'b0}}, rnd};
        state_next = accept ? RUN : last ? IDLE : state;
    end

    always_ff @(posedge crypto_clk or posedge crypto_rst) begin
        if (crypto_rst) state <= IDLE;
        else state <= state_next;
    end

    // Ready and idle come straight from the state flop, so the trigger is glitch-free.
    assign crypto_ready = (state == IDLE);
    assign crypto_idle  = (state == IDLE);

    always_ff @(posedge crypto_clk or posedge crypto_rst) begin
        if (crypto_rst) begin
            st              <= '0;
            key_reg         <= '0;
            rnd             <= '0;
            crypto_cipherin <= '0;
            crypto_done     <= 1'b0;
        end else if (accept) begin
            key_reg     <= crypto_keyout;
            st          <= crypto_textout ^ crypto_keyout;
            rnd         <= 8'd1;
            crypto_done <= 1'b0;
        end else if (state == RUN) begin
            st <= st_round;
            if (last) begin
                crypto_cipherin <= st_round;
                crypto_done     <= 1'b1;
            end else begin
                rnd <= rnd + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_crypto_block_responder.sv
// tb_crypto_block_responder: randomized and directed checks of the block responder
// against a plain-arithmetic reference model, using ROUNDS = 10, 2 and 1 instances.
module tb_crypto_block_responder;
    localparam int W = 128;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [W-1:0] key = '0, text = '0;
    logic [W-1:0] c10, c2, c1;
    logic r10, d10, i10, r2, d2, i2, r1, d1, i1;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    crypto_block_responder #(.WIDTH(W), .ROUNDS(10)) dut (
        .crypto_clk(clk), .crypto_rst(rst), .crypto_keyout(key), .crypto_textout(text),
        .crypto_start(start), .crypto_cipherin(c10), .crypto_ready(r10),
        .crypto_done(d10), .crypto_idle(i10));
    crypto_block_responder #(.WIDTH(W), .ROUNDS(2)) dut2 (
        .crypto_clk(clk), .crypto_rst(rst), .crypto_keyout(key), .crypto_textout(text),
        .crypto_start(start), .crypto_cipherin(c2), .crypto_ready(r2),
        .crypto_done(d2), .crypto_idle(i2));
    crypto_block_responder #(.WIDTH(W), .ROUNDS(1)) dut1 (
        .crypto_clk(clk), .crypto_rst(rst), .crypto_keyout(key), .crypto_textout(text),
        .crypto_start(start), .crypto_cipherin(c1), .crypto_ready(r1),
        .crypto_done(d1), .crypto_idle(i1));

    function automatic logic [W-1:0] model(input logic [W-1:0] k, input logic [W-1:0] t, input int rounds);
        logic [W-1:0] s;
        s = t ^ k;
        for (int r = 1; r <= rounds; r++) begin
            s = ((s << 1) | (s >> (W - 1))) ^ k ^ W'(r % 256);
        end
        return s;
    endfunction

    function automatic logic [W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic launch(input logic [W-1:0] k, input logic [W-1:0] t);
        @(negedge clk);
        key = k; text = t; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (i10 === 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (c10 !== '0 || r10 !== 1'b1 || d10 !== 1'b0 || i10 !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold: cipher=%h ready=%b done=%b idle=%b want 0/1/0/1", c10, r10, d10, i10);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (c10 !== '0 || r10 !== 1'b1 || d10 !== 1'b0 || i10 !== 1'b1 || d2 !== 1'b0 || d1 !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle%0d: cipher=%h ready=%b done=%b idle=%b want 0/1/0/1", i, c10, r10, d10, i10);
            end
        end
    endtask

    task automatic test_default();
        int n;
        launch('0, '0);
        wait_busy(n);
        checks++;
        if (n !== 10 || c10 !== W'(8'h40) || d10 !== 1'b1) begin
            failures++;
            $display("FAIL default_kat: busy=%0d cipher=%h done=%b want 10/40/1", n, c10, d10);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (d10 !== 1'b1 || c10 !== W'(8'h40) || i10 !== 1'b1) begin
                failures++;
                $display("FAIL done_hold%0d: done=%b cipher=%h idle=%b want 1/40/1", i, d10, c10, i10);
            end
        end
    endtask

    task automatic test_short();
        launch('0, '0);
        @(negedge clk);
        checks++;
        if (i2 !== 1'b0 || d2 !== 1'b0) begin
            failures++;
            $display("FAIL r2_busy: idle=%b done=%b want 0/0", i2, d2);
        end
        @(negedge clk);
        checks++;
        if (c2 !== '0 || d2 !== 1'b1 || i2 !== 1'b1) begin
            failures++;
            $display("FAIL r2_kat: cipher=%h done=%b idle=%b want 0/1/1", c2, d2, i2);
        end
        launch('0, W'(1));
        checks++;
        if (i1 !== 1'b0 || d1 !== 1'b0) begin
            failures++;
            $display("FAIL r1_busy: idle=%b done=%b want 0/0", i1, d1);
        end
        @(negedge clk);
        checks++;
        if (c1 !== W'(3) || d1 !== 1'b1 || i1 !== 1'b1) begin
            failures++;
            $display("FAIL r1_kat: cipher=%h done=%b idle=%b want 3/1/1", c1, d1, i1);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_ignored();
        int n;
        launch('0, '0);
        repeat (3) @(negedge clk);
        key = '1; text = rand_word(); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_busy(n);
        checks++;
        if (n + 4 !== 10 || c10 !== W'(8'h40) || d10 !== 1'b1) begin
            failures++;
            $display("FAIL ignored_start: busy=%0d cipher=%h done=%b want 10/40/1", n + 4, c10, d10);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (i10 !== 1'b1 || d10 !== 1'b1) begin
                failures++;
                $display("FAIL ignored_no_rerun%0d: idle=%b done=%b want 1/1", i, i10, d10);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        key = '0; text = '0; start = 1'b1;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            checks++;
            if (i10 !== (i % 11 == 10) || d10 !== (i % 11 == 10) || r10 !== (i % 11 == 10)) begin
                failures++;
                $display("FAIL held_cycle%0d: idle=%b done=%b ready=%b want %b", i, i10, d10, r10, (i % 11 == 10));
            end
            if (i % 11 == 10) begin
                checks++;
                if (c10 !== W'(8'h40)) begin
                    failures++;
                    $display("FAIL held_cipher%0d: cipher=%h want 40", i, c10);
                end
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (i10 !== 1'b1 || d10 !== 1'b1) begin
            failures++;
            $display("FAIL held_release: idle=%b done=%b want 1/1", i10, d10);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        launch('0, '0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (c10 !== '0 || r10 !== 1'b1 || d10 !== 1'b0 || i10 !== 1'b1) begin
            failures++;
            $display("FAIL reset_async: cipher=%h ready=%b done=%b idle=%b want 0/1/0/1", c10, r10, d10, i10);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (d10 !== 1'b0 || i10 !== 1'b1 || c10 !== '0) begin
                failures++;
                $display("FAIL reset_abort%0d: done=%b idle=%b cipher=%h want 0/1/0", i, d10, i10, c10);
            end
        end
        launch('0, '0);
        wait_busy(n);
        checks++;
        if (n !== 10 || c10 !== W'(8'h40) || d10 !== 1'b1) begin
            failures++;
            $display("FAIL reset_recover: busy=%0d cipher=%h done=%b want 10/40/1", n, c10, d10);
        end
    endtask

    task automatic test_random();
        int n;
        logic [W-1:0] k, t;
        for (int b = 0; b < 8; b++) begin
            k = rand_word();
            t = rand_word();
            launch(k, t);
            wait_busy(n);
            checks++;
            if (n !== 10 || d10 !== 1'b1 || c10 !== model(k, t, 10)) begin
                failures++;
                $display("FAIL random10_%0d: busy=%0d done=%b cipher=%h want %h", b, n, d10, c10, model(k, t, 10));
            end
            checks++;
            if (d2 !== 1'b1 || c2 !== model(k, t, 2) || d1 !== 1'b1 || c1 !== model(k, t, 1)) begin
                failures++;
                $display("FAIL random_short_%0d: c2=%h want %h c1=%h want %h", b, c2, model(k, t, 2), c1, model(k, t, 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_short();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
